// File: rtl/flopoco_pkg.sv
// FloPoCo 11/52 operand format: exception codes, field positions and ordering rank.
package flopoco_pkg;

  localparam int unsigned EXC_HI   = 65;
  localparam int unsigned EXC_LO   = 64;
  localparam int unsigned SIGN_BIT = 63;
  localparam int unsigned EXP_HI   = 62;
  localparam int unsigned EXP_LO   = 52;
  localparam int unsigned FRAC_HI  = 51;
  localparam int unsigned FRAC_LO  = 0;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  localparam logic [EXC_HI:0] FP_NAN_CANON = {EXC_NAN, 64'b0};

  // Encoding order is the numeric order of the classes; NaN sits outside it.
  typedef enum logic [2:0] {
    RANK_NEG_INF,
    RANK_NEG_NORM,
    RANK_ZERO,
    RANK_POS_NORM,
    RANK_POS_INF,
    RANK_NAN
  } rank_e;

  function automatic rank_e fp_rank(input logic [1:0] exc, input logic sign);
    rank_e r;
    case (exc)
      EXC_ZERO: r = RANK_ZERO;
      EXC_NORM: r = sign ? RANK_NEG_NORM : RANK_POS_NORM;
      EXC_INF:  r = sign ? RANK_NEG_INF : RANK_POS_INF;
      default:  r = RANK_NAN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flopoco_lt.sv
// Combinational strict a < b on FloPoCo operands, plus a NaN-present flag.
module flopoco_lt
  import flopoco_pkg::*;
(
  input  logic [EXC_HI:0] a,
  input  logic [EXC_HI:0] b,
  output logic            lt,
  output logic            nan
);

  rank_e ra;
  rank_e rb;
  logic [EXP_HI:0] ma;
  logic [EXP_HI:0] mb;

  always_comb begin
    ra  = fp_rank(a[EXC_HI:EXC_LO], a[SIGN_BIT]);
    rb  = fp_rank(b[EXC_HI:EXC_LO], b[SIGN_BIT]);
    ma  = {a[EXP_HI:EXP_LO], a[FRAC_HI:FRAC_LO]};
    mb  = {b[EXP_HI:EXP_LO], b[FRAC_HI:FRAC_LO]};
    nan = (ra == RANK_NAN) || (rb == RANK_NAN);
    lt  = 1'b0;
    // Zeros and infinities of one class are equal; only normals look at magnitude.
    if (ra != rb)
      lt = (ra < rb);
    else if (ra == RANK_NEG_NORM)
      lt = (ma > mb);
    else if (ra == RANK_POS_NORM)
      lt = (ma < mb);
  end

endmodule

// File: rtl/slab_interval_reduce.sv
// Two-stage max(tnear)/min(tfar) reduction with a tag/valid/NaN delay line aligned
// to the downstream greater_or_equal flag, and a saturating NaN-beat counter.
module slab_interval_reduce
  import flopoco_pkg::*;
#(
  parameter int unsigned width   = 65,
  parameter int unsigned id_w    = 16,
  parameter int unsigned cmp_lat = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [id_w-1:0]  id_i,
  input  logic [width:0]   tnx,
  input  logic [width:0]   tny,
  input  logic [width:0]   tnz,
  input  logic [width:0]   tfx,
  input  logic [width:0]   tfy,
  input  logic [width:0]   tfz,
  output logic             valid_o,
  output logic [width:0]   tenter,
  output logic [width:0]   texit,
  output logic             nan_o,
  output logic             valid_al_o,
  output logic [id_w-1:0]  id_al_o,
  output logic             nan_al_o,
  output logic [15:0]      nan_cnt
);

  logic lt_max1, nan_max1, lt_min1, nan_min1;
  logic lt_max2, nan_max2, lt_min2, nan_min2;

  logic            v1;
  logic [id_w-1:0] id1;
  logic [width:0]  m1, n1, tnz_r, tfz_r;
  logic            nan1;
  logic [id_w-1:0] id2;

  // Ties go to the earlier axis: max swaps only on a < b, min only on later < earlier.
  flopoco_lt u_max1 (.a(tnx), .b(tny), .lt(lt_max1), .nan(nan_max1));
  flopoco_lt u_min1 (.a(tfy), .b(tfx), .lt(lt_min1), .nan(nan_min1));
  flopoco_lt u_max2 (.a(m1), .b(tnz_r), .lt(lt_max2), .nan(nan_max2));
  flopoco_lt u_min2 (.a(tfz_r), .b(n1), .lt(lt_min2), .nan(nan_min2));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      id1   <= '0;
      m1    <= '0;
      n1    <= '0;
      tnz_r <= '0;
      tfz_r <= '0;
      nan1  <= 1'b0;
    end else begin
      v1    <= valid_i;
      id1   <= id_i;
      m1    <= lt_max1 ? tny : tnx;
      n1    <= lt_min1 ? tfy : tfx;
      tnz_r <= tnz;
      tfz_r <= tfz;
      nan1  <= nan_max1 | nan_min1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      id2     <= '0;
      nan_o   <= 1'b0;
      tenter  <= '0;
      texit   <= '0;
    end else begin
      valid_o <= v1;
      id2     <= id1;
      nan_o   <= nan1 | nan_max2 | nan_min2;
      if (nan1 | nan_max2 | nan_min2) begin
        tenter <= FP_NAN_CANON;
        texit  <= FP_NAN_CANON;
      end else begin
        tenter <= lt_max2 ? tnz_r : m1;
        texit  <= lt_min2 ? tfz_r : n1;
      end
    end
  end

  logic [cmp_lat-1:0] vd;
  logic [cmp_lat-1:0] nd;
  logic [id_w-1:0]    idd [cmp_lat];

  always_ff @(posedge clk) begin
    if (rst) begin
      vd <= '0;
      nd <= '0;
      for (int unsigned i = 0; i < cmp_lat; i++) idd[i] <= '0;
    end else begin
      vd[0]  <= valid_o;
      nd[0]  <= nan_o;
      idd[0] <= id2;
      for (int unsigned i = 1; i < cmp_lat; i++) begin
        vd[i]  <= vd[i-1];
        nd[i]  <= nd[i-1];
        idd[i] <= idd[i-1];
      end
    end
  end

  assign valid_al_o = vd[cmp_lat-1];
  assign nan_al_o   = nd[cmp_lat-1];
  assign id_al_o    = idd[cmp_lat-1];

  always_ff @(posedge clk) begin
    if (rst)
      nan_cnt <= '0;
    else if (valid_o && nan_o && (nan_cnt != '1))
      nan_cnt <= nan_cnt + 16'd1;
  end

endmodule

// File: tb/tb_slab_interval_reduce.sv
// Directed bench for slab_interval_reduce: vector table for the reduction, per-cycle
// history model for valid/tag alignment at cmp_lat 4, 1 and 8, NaN counter sequences.
module tb_slab_interval_reduce;

  localparam logic [65:0] P1   = {2'b01, 1'b0, 11'h3FF, 52'h0};
  localparam logic [65:0] P2   = {2'b01, 1'b0, 11'h400, 52'h0};
  localparam logic [65:0] P3   = {2'b01, 1'b0, 11'h400, 52'h8000000000000};
  localparam logic [65:0] P4   = {2'b01, 1'b0, 11'h401, 52'h0};
  localparam logic [65:0] P5   = {2'b01, 1'b0, 11'h401, 52'h4000000000000};
  localparam logic [65:0] P6   = {2'b01, 1'b0, 11'h401, 52'h8000000000000};
  localparam logic [65:0] P7   = {2'b01, 1'b0, 11'h401, 52'hC000000000000};
  localparam logic [65:0] N1   = {2'b01, 1'b1, 11'h3FF, 52'h0};
  localparam logic [65:0] N1P5 = {2'b01, 1'b1, 11'h3FF, 52'h8000000000000};
  localparam logic [65:0] N2   = {2'b01, 1'b1, 11'h400, 52'h0};
  localparam logic [65:0] N3   = {2'b01, 1'b1, 11'h400, 52'h8000000000000};
  localparam logic [65:0] N5   = {2'b01, 1'b1, 11'h401, 52'h4000000000000};
  localparam logic [65:0] PZ   = {2'b00, 1'b0, 63'h0};
  localparam logic [65:0] NZ   = {2'b00, 1'b1, 63'h0};
  localparam logic [65:0] PINF = {2'b10, 1'b0, 63'h0};
  localparam logic [65:0] NINF = {2'b10, 1'b1, 63'h0};
  localparam logic [65:0] QNAN = {2'b11, 1'b0, 11'h7FF, 52'h1};
  localparam logic [65:0] CNAN = {2'b11, 64'h0};
  localparam int HIST = 131072;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [15:0] id_i = '0;
  logic [65:0] tnx = '0, tny = '0, tnz = '0, tfx = '0, tfy = '0, tfz = '0;

  logic        v4, n4, va4, na4, va1, na1, va8, na8, v1o, n1o, v8o, n8o;
  logic [65:0] te4, tx4, te1, tx1, te8, tx8;
  logic [15:0] ida4, ida1, ida8, cnt4, cnt1, cnt8;

  slab_interval_reduce #(.width(65), .id_w(16), .cmp_lat(4)) u_l4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .id_i(id_i),
    .tnx(tnx), .tny(tny), .tnz(tnz), .tfx(tfx), .tfy(tfy), .tfz(tfz),
    .valid_o(v4), .tenter(te4), .texit(tx4), .nan_o(n4),
    .valid_al_o(va4), .id_al_o(ida4), .nan_al_o(na4), .nan_cnt(cnt4));

  slab_interval_reduce #(.width(65), .id_w(16), .cmp_lat(1)) u_l1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .id_i(id_i),
    .tnx(tnx), .tny(tny), .tnz(tnz), .tfx(tfx), .tfy(tfy), .tfz(tfz),
    .valid_o(v1o), .tenter(te1), .texit(tx1), .nan_o(n1o),
    .valid_al_o(va1), .id_al_o(ida1), .nan_al_o(na1), .nan_cnt(cnt1));

  slab_interval_reduce #(.width(65), .id_w(16), .cmp_lat(8)) u_l8 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .id_i(id_i),
    .tnx(tnx), .tny(tny), .tnz(tnz), .tfx(tfx), .tfy(tfy), .tfz(tfz),
    .valid_o(v8o), .tenter(te8), .texit(tx8), .nan_o(n8o),
    .valid_al_o(va8), .id_al_o(ida8), .nan_al_o(na8), .nan_cnt(cnt8));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          hv [HIST];
  bit          hr [HIST];
  bit          hn [HIST];
  logic [15:0] hid [HIST];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_nan(input logic [65:0] x);
    return x[65:64] == 2'b11;
  endfunction

  // A beat presented in cycle k shows up in cycle k+2+lat unless a reset is
  // presented in any of cycles k .. k+1+lat.
  function automatic bit exp_valid(input int c, input int lat);
    int k;
    k = c - 2 - lat;
    if (k < 0 || !hv[k]) return 1'b0;
    for (int r = k; r <= k + 1 + lat; r++)
      if (hr[r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mon(input string nm, input int lat, input int c, input logic v,
                     input logic [15:0] idv, input logic nv, input bit has_id);
    bit ev;
    ev = exp_valid(c, lat);
    chk({nm, "_valid"}, {65'b0, v}, {65'b0, ev});
    if (ev) begin
      if (has_id) chk({nm, "_id"}, {50'b0, idv}, {50'b0, hid[c-2-lat]});
      chk({nm, "_nan"}, {65'b0, nv}, {65'b0, hn[c-2-lat]});
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cyc < HIST) begin
      mon("l4_valid_o", 0, cyc, v4, 16'h0, n4, 1'b0);
      mon("l4_al", 4, cyc, va4, ida4, na4, 1'b1);
      mon("l1_al", 1, cyc, va1, ida1, na1, 1'b1);
      mon("l8_al", 8, cyc, va8, ida8, na8, 1'b1);
    end
  end

  task automatic tick();
    hv[cyc]  = valid_i;
    hr[cyc]  = rst;
    hid[cyc] = id_i;
    hn[cyc]  = is_nan(tnx) | is_nan(tny) | is_nan(tnz) |
               is_nan(tfx) | is_nan(tfy) | is_nan(tfz);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [65:0] a, b, c, d, e, f);
    tnx = a; tny = b; tnz = c; tfx = d; tfy = e; tfz = f;
  endtask

  typedef struct {
    string       name;
    logic [65:0] nx, ny, nz, fx, fy, fz;
    logic [15:0] id;
    logic [65:0] enter, exit_v;
    logic        nan;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"ordinary",      P1,   P3,   P2,   P5,   P4,   P6,  16'd7,  P3,   P4,   1'b0};
    vecs[1]  = '{"zero_tie_x",    NZ,   PZ,   N1,   P1,   P1,   P1,  16'd8,  NZ,   P1,   1'b0};
    vecs[2]  = '{"tf_all_equal",  N1,   N2,   N3,   P2,   P2,   P2,  16'd9,  N1,   P2,   1'b0};
    vecs[3]  = '{"zero_tie_mix",  PZ,   N5,   NZ,   P7,   NZ,   PZ,  16'd10, PZ,   NZ,   1'b0};
    vecs[4]  = '{"inf_neg",       NINF, N2,   N3,   PINF, PINF, P1,  16'd11, N2,   P1,   1'b0};
    vecs[5]  = '{"neg_frac",      N1,   N1P5, N2,   N1,   N3,   PINF, 16'd12, N1,  N3,   1'b0};
    vecs[6]  = '{"inf_pick",      P2,   PINF, P1,   P5,   NINF, PZ,  16'd13, PINF, NINF, 1'b0};
    vecs[7]  = '{"pos_frac",      P5,   P6,   P4,   P6,   P5,   P7,  16'd14, P6,   P5,   1'b0};
    vecs[8]  = '{"nan_tnz",       P1,   P2,   QNAN, P5,   P4,   P6,  16'd15, CNAN, CNAN, 1'b1};
    vecs[9]  = '{"nan_tfx",       P1,   P2,   P3,   QNAN, P4,   P6,  16'd16, CNAN, CNAN, 1'b1};
    vecs[10] = '{"nan_tnx",       QNAN, P2,   P3,   P5,   P4,   P6,  16'd17, CNAN, CNAN, 1'b1};

    // Reset, with a valid beat offered during reset that must be ignored.
    rst = 1'b1; valid_i = 1'b1; id_i = 16'hBEEF;
    set_ops(P1, P2, P3, P4, P5, P6);
    repeat (3) tick();
    rst = 1'b0; valid_i = 1'b0;
    tick();
    chk("reset_valid_o", {65'b0, v4}, 66'd0);
    chk("reset_tenter", te4, 66'd0);
    chk("reset_texit", tx4, 66'd0);
    chk("reset_nan_o", {65'b0, n4}, 66'd0);
    chk("reset_nan_cnt", {50'b0, cnt4}, 66'd0);
    chk("reset_id_al", {50'b0, ida4}, 66'd0);
    chk("reset_nan_al", {65'b0, na4}, 66'd0);

    foreach (vecs[i]) begin
      set_ops(vecs[i].nx, vecs[i].ny, vecs[i].nz, vecs[i].fx, vecs[i].fy, vecs[i].fz);
      id_i = vecs[i].id; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tick();
      chk({vecs[i].name, "_tenter"}, te4, vecs[i].enter);
      chk({vecs[i].name, "_texit"}, tx4, vecs[i].exit_v);
      chk({vecs[i].name, "_nan_o"}, {65'b0, n4}, {65'b0, vecs[i].nan});
    end
    repeat (12) tick();
    chk("table_nan_cnt", {50'b0, cnt4}, 66'd3);

    rst = 1'b1; tick(); rst = 1'b0;

    // NaN run: three back-to-back beats, then fill up to and past saturation.
    set_ops(P1, P3, P2, P5, QNAN, P6);
    for (int i = 0; i < 5; i++) begin
      valid_i = (i < 3); id_i = 16'(40 + i);
      tick();
      if (i >= 1 && i <= 3) begin
        chk("nanrun_nan_o", {65'b0, n4}, 66'd1);
        chk("nanrun_tenter", te4, CNAN);
        chk("nanrun_texit", tx4, CNAN);
      end
    end
    chk("nanrun_cnt3", {50'b0, cnt4}, 66'd3);
    valid_i = 1'b1;
    for (int i = 0; i < 65531; i++) begin
      id_i = 16'(i);
      tick();
    end
    valid_i = 1'b0;
    repeat (3) tick();
    chk("nanrun_cnt_fffe", {50'b0, cnt4}, 66'h0FFFE);
    chk("nanrun_cnt_l8_fffe", {50'b0, cnt8}, 66'h0FFFE);
    valid_i = 1'b1;
    repeat (3) tick();
    valid_i = 1'b0;
    repeat (4) tick();
    chk("nanrun_cnt_sat", {50'b0, cnt4}, 66'h0FFFF);
    chk("nanrun_cnt_l1_sat", {50'b0, cnt1}, 66'h0FFFF);

    // Streaming with a one-cycle reset where beat 6 would have been presented.
    set_ops(P1, P3, P2, P5, P4, P6);
    repeat (10) tick();
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1; id_i = 16'(100 + i); rst = (i == 6);
      tick();
      if (i == 6) begin
        chk("post_reset_valid_o", {65'b0, v4}, 66'd0);
        chk("post_reset_al4", {65'b0, va4}, 66'd0);
        chk("post_reset_al1", {65'b0, va1}, 66'd0);
        chk("post_reset_al8", {65'b0, va8}, 66'd0);
        chk("post_reset_cnt", {50'b0, cnt4}, 66'd0);
      end
    end
    rst = 1'b0; valid_i = 1'b0;
    repeat (3) tick();
    chk("stream_tenter", te4, P3);
    chk("stream_texit", tx4, P4);
    repeat (12) tick();
    chk("stream_nan_cnt", {50'b0, cnt4}, 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slab_interval_reduce.md
# slab_interval_reduce

Pipelined reduction stage that sits directly upstream of `greater_or_equal` in the ray/AABB slab test. It takes the three per-axis slab entry distances (`tnear`) and exit distances (`tfar`) in FloPoCo 11/52 format. It produces `tenter = max(tnear)` and `texit = min(tfar)`, which feed `greater_or_equal` as `inA = texit` and `inB = tenter`. It also carries a ray tag and valid through a delay line, so that tag and valid line up with the registered `greater_or_equal` flag.

## Interface

**Parameters**
- `width`, default 65: operand MSB index. Operands are `[width:0]`, 66 bits. Bit layout: `[65:64]` exception, `[63]` sign, `[62:52]` exponent, `[51:0]` fraction.
- `id_w`, default 16: ray tag width.
- `cmp_lat`, default 4: latency of the downstream `greater_or_equal`, i.e. FPSub pipeline depth plus its output register. Must be ≥1.

**Ports** (clock and reset listed first)
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `valid_i`, in, 1: input beat valid. No backpressure.
- `id_i`, in, `id_w`: ray tag.
- `tnx`, `tny`, `tnz`, in, `width+1` each: per-axis entry distances.
- `tfx`, `tfy`, `tfz`, in, `width+1` each: per-axis exit distances.
- `valid_o`, out, 1: `tenter`/`texit` valid.
- `tenter`, out, `width+1`: max of the `tn*` inputs.
- `texit`, out, `width+1`: min of the `tf*` inputs.
- `nan_o`, out, 1: at least one of the six inputs was NaN.
- `valid_al_o`, out, 1: `valid_o` delayed by `cmp_lat`.
- `id_al_o`, out, `id_w`: `id` delayed by `cmp_lat`.
- `nan_al_o`, out, 1: `nan_o` delayed by `cmp_lat`.
- `nan_cnt`, out, 16: saturating count of NaN beats.

## Operation

**Operand ordering.** Classes are ranked -inf < -normal < zero < +normal < +inf.
- Exception 00 (zero) ignores the sign bit, so +0 equals -0.
- Normals of equal sign compare by `{exp,frac}` as unsigned. The order is reversed for negative values.
- Exception 11 is NaN and is handled separately (see NaN handling).

**Ties.** On equal operands, the earlier axis operand wins, in order x, then y, then z. The output is bit-exact equal to that winning input, including the sign of zero.

**Stage 1** (registered at the edge after the input is sampled):
- `m1 = max(tnx, tny)`, `n1 = min(tfx, tfy)`.
- `tnz`, `tfz`, `id`, `valid` and the partial NaN flag are registered alongside.

**Stage 2:**
- `tenter = max(m1, tnz_r)`, `texit = min(n1, tfz_r)`.
- `nan_o` is the OR of the NaN status of all six inputs.

**NaN handling.** When `nan_o` = 1, both `tenter` and `texit` are forced to the canonical NaN `{2'b11, 64'b0}`. The tag still propagates normally.

**Aligned outputs.** A shift register of depth `cmp_lat` delays `valid_o`, `id` and `nan_o` to form the `*_al_o` outputs. Operand values are not delayed.

**NaN counter.** `nan_cnt` increments when a beat with `valid_o`=1 and `nan_o`=1 leaves stage 2. It saturates at 16'hFFFF and does not wrap.

**Invalid beats.** While `valid_i`=0, the data registers may hold stale values. Valid bits are always clean. `nan_cnt` ignores beats with `valid_o`=0.

## Timing

- Input to `tenter`/`texit`/`valid_o`/`nan_o`: latency 2 cycles, throughput 1 beat per cycle.
- Input to `*_al_o`: latency `2 + cmp_lat` cycles. `valid_al_o` is high in exactly the cycle the `greater_or_equal` flag for that beat is registered.
- Back-to-back beats are never merged or dropped.
- **Reset values:**
  - `valid_o`, `valid_al_o`, `nan_o`, `nan_al_o`, `id_al_o`: 0.
  - `tenter`, `texit`: all zeros.
  - `nan_cnt`: 0.
  - All stage-valid and delay-line valid bits: 0.
- **Reset during operation:** every in-flight beat is discarded. All valid outputs are 0 in the first cycle after `rst` is sampled high, and stay 0 until new input beats have propagated through.
- **Input in the reset cycle:** `valid_i` asserted while `rst` is high is ignored.

## Structure

- **Shared package** `flopoco_pkg`:
  - exception codes `EXC_ZERO`=2'b00, `EXC_NORM`=2'b01, `EXC_INF`=2'b10, `EXC_NAN`=2'b11;
  - field position constants for the exception, sign, exponent and fraction fields;
  - canonical NaN constant `FP_NAN_CANON`.
- **Sub-module** `flopoco_lt`: purely combinational strict less-than on two operands, with a NaN-in output. It is instantiated 4 times: two max and two min, one pair per stage.
- **Top level:** the two pipeline stages, the `cmp_lat` delay line and the NaN counter.

## Test plan

1. **Ordinary reduction.**
   - Stimulus: `tn` = 1.0, 3.0, 2.0; `tf` = 5.0, 4.0, 6.0; `id`=7.
   - Response: 2 cycles later `tenter`=3.0, `texit`=4.0. Then `cmp_lat` cycles after that, `valid_al_o`=1 with `id_al_o`=7.
2. **Zero sign and ties.**
   - Stimulus A: `tnx`=-0, `tny`=+0, `tnz`=-1.0.
   - Response A: `tenter` = bit-exact -0 (x wins the tie).
   - Stimulus B: all three `tf` = 2.0.
   - Response B: `texit` equals `tfx`.
3. **Infinities and negatives.**
   - Stimulus: `tn` = -inf, -2.0, -3.0; `tf` = +inf, +inf, 1.0.
   - Response: `tenter`=-2.0, `texit`=1.0.
4. **NaN handling.**
   - Stimulus: `tfy`=NaN in 3 consecutive beats.
   - Response: in each, `nan_o`=1 and both outputs equal `FP_NAN_CANON`. `nan_cnt` reads 3. Preloading the counter to FFFE and sending 3 more NaN beats leaves it at FFFF.
5. **Streaming and mid-flight reset.**
   - Stimulus: 10 back-to-back beats with ids 0..9, then `rst` pulsed for 1 cycle after beat 5 is sampled.
   - Response: beats 0..5 complete only if they cleared the pipeline before the reset edge. No valid output appears in the cycle after reset. `nan_cnt`=0.
6. **Latency sweep.**
   - Stimulus: `cmp_lat` set to 1 and to 8.
   - Response: `valid_al_o` rises exactly `2+cmp_lat` cycles after `valid_i`, checked against a scoreboard.
